mem_stage: RTL and testbench

Load/store stage between `alu_stage` and `regWrite_stage`. It takes the ALU's effective address and store data and runs the access through the data-side port of `cpu_memctl` (`mem_addr`, `mem_re`, `mem_we`, `mem_dataOut`), honouring its wait signal. Byte stores are done as a read-modify-write, and byte loads are extracted and optionally sign-extended. It hands a single registered result plus a one-cycle done pulse to the register-write stage; non-memory instructions pass through unchanged.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Load/store stage: runs ALU-computed accesses through the cpu_memctl data port
// and returns one registered result with a single-cycle done pulse.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  op_i,
  input  logic        byte_i,
  input  logic        signExt_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] storeData_i,
  input  logic [15:0] aluResult_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [15:0] mem_dataOut_o,
  input  logic [15:0] mem_dataIn_i,
  input  logic        mem_needWait_i,
  output logic [15:0] result_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        fault_o,
  output logic [1:0]  state_o
);

  // Handshake: en is a one-shot request taken only while busy_o is low (never
  // queued); done_o marks result_o/fault_o valid for exactly one cycle. On the
  // memory side a strobe is held, with address and data frozen, until
  // mem_needWait_i is sampled low.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        load_q;
  logic        byte_q;
  logic        sign_q;
  logic        lane_q;
  logic [7:0]  store_byte_q;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [7:0]  rd_lane;
  logic [15:0] load_val;
  logic [15:0] merge_val;

  always_comb begin
    is_load    = (op_i == 2'b01);
    is_store   = (op_i == 2'b10);
    misaligned = (is_load || is_store) && !byte_i && addr_i[0];
    rd_lane    = lane_q ? mem_dataIn_i[15:8] : mem_dataIn_i[7:0];
    load_val   = mem_dataIn_i;
    if (byte_q) begin
      load_val = {(sign_q ? {8{rd_lane[7]}} : 8'h00), rd_lane};
    end
    // Byte store keeps the untouched lane from the word just read.
    merge_val  = lane_q ? {store_byte_q, mem_dataIn_i[7:0]}
                        : {mem_dataIn_i[15:8], store_byte_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      load_q        <= 1'b0;
      byte_q        <= 1'b0;
      sign_q        <= 1'b0;
      lane_q        <= 1'b0;
      store_byte_q  <= 8'h00;
      mem_addr_o    <= 16'h0000;
      mem_dataOut_o <= 16'h0000;
      result_o      <= 16'h0000;
      fault_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            load_q       <= is_load;
            byte_q       <= byte_i;
            sign_q       <= signExt_i;
            lane_q       <= addr_i[0];
            store_byte_q <= storeData_i[7:0];
            mem_addr_o   <= {addr_i[15:1], 1'b0};
            if (misaligned) begin
              result_o <= 16'h0000;
              fault_o  <= 1'b1;
              state    <= DONE;
            end else if (is_load) begin
              state <= READ;
            end else if (is_store) begin
              if (byte_i) begin
                state <= READ;
              end else begin
                mem_dataOut_o <= storeData_i;
                state         <= WRITE;
              end
            end else begin
              result_o <= aluResult_i;
              fault_o  <= 1'b0;
              state    <= DONE;
            end
          end
        end
        READ: begin
          if (!mem_needWait_i) begin
            if (load_q) begin
              result_o <= load_val;
              fault_o  <= 1'b0;
              state    <= DONE;
            end else begin
              mem_dataOut_o <= merge_val;
              state         <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!mem_needWait_i) begin
            result_o <= 16'h0000;
            fault_o  <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_re_o = (state == READ);
  assign mem_we_o = (state == WRITE);
  assign done_o   = (state == DONE);
  assign busy_o   = (state != IDLE);
  assign state_o  = state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  op_i;
  logic        byte_i;
  logic        signExt_i;
  logic [15:0] addr_i;
  logic [15:0] storeData_i;
  logic [15:0] aluResult_i;
  logic [15:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [15:0] mem_dataOut_o;
  logic [15:0] mem_dataIn_i;
  logic        mem_needWait_i;
  logic [15:0] result_o;
  logic        done_o;
  logic        busy_o;
  logic        fault_o;
  logic [1:0]  state_o;

  int n_cmp;
  int n_fail;
  int re_cnt;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .op_i           (op_i),
    .byte_i         (byte_i),
    .signExt_i      (signExt_i),
    .addr_i         (addr_i),
    .storeData_i    (storeData_i),
    .aluResult_i    (aluResult_i),
    .mem_addr_o     (mem_addr_o),
    .mem_re_o       (mem_re_o),
    .mem_we_o       (mem_we_o),
    .mem_dataOut_o  (mem_dataOut_o),
    .mem_dataIn_i   (mem_dataIn_i),
    .mem_needWait_i (mem_needWait_i),
    .result_o       (result_o),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request; returns just after the sampling edge E with en dropped.
  task automatic launch(input logic [1:0] op, input logic b, input logic s,
                        input logic [15:0] addr, input logic [15:0] sd,
                        input logic [15:0] alu);
    op_i        = op;
    byte_i      = b;
    signExt_i   = s;
    addr_i      = addr;
    storeData_i = sd;
    aluResult_i = alu;
    en          = 1'b1;
    step();
    en          = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_re"},    {15'd0, mem_re_o}, 16'h0000);
    chk({tag, "_we"},    {15'd0, mem_we_o}, 16'h0000);
    chk({tag, "_done"},  {15'd0, done_o},   16'h0000);
    chk({tag, "_busy"},  {15'd0, busy_o},   16'h0000);
    chk({tag, "_fault"}, {15'd0, fault_o},  16'h0000);
    chk({tag, "_addr"},  mem_addr_o,        16'h0000);
    chk({tag, "_dout"},  mem_dataOut_o,     16'h0000);
    chk({tag, "_res"},   result_o,          16'h0000);
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    en             = 1'b0;
    op_i           = 2'b00;
    byte_i         = 1'b0;
    signExt_i      = 1'b0;
    addr_i         = 16'h0000;
    storeData_i    = 16'h0000;
    aluResult_i    = 16'h0000;
    mem_dataIn_i   = 16'h0000;
    mem_needWait_i = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_state", {14'd0, state_o}, 16'h0000);
    rst = 1'b0;
    step();

    // Pass: done one cycle after E, then result holds.
    launch(2'b00, 1'b0, 1'b0, 16'h0001, 16'h5555, 16'h1234);
    chk("pass_done",  {15'd0, done_o},   16'h0001);
    chk("pass_res",   result_o,          16'h1234);
    chk("pass_fault", {15'd0, fault_o},  16'h0000);
    chk("pass_re",    {15'd0, mem_re_o}, 16'h0000);
    chk("pass_we",    {15'd0, mem_we_o}, 16'h0000);
    step();
    chk("pass_done_drop", {15'd0, done_o}, 16'h0000);
    chk("pass_idle",      {15'd0, busy_o}, 16'h0000);
    chk("pass_hold",      result_o,        16'h1234);

    // Byte load, high lane, sign-extended: 0x80FF @ 0x0100 -> 0xFF80.
    mem_dataIn_i = 16'h80FF;
    launch(2'b01, 1'b1, 1'b1, 16'h0101, 16'h0000, 16'h0000);
    chk("bls_re",   {15'd0, mem_re_o}, 16'h0001);
    chk("bls_we",   {15'd0, mem_we_o}, 16'h0000);
    chk("bls_addr", mem_addr_o,        16'h0100);
    chk("bls_busy", {15'd0, busy_o},   16'h0001);
    chk("bls_nodone", {15'd0, done_o}, 16'h0000);
    step();
    chk("bls_done", {15'd0, done_o},   16'h0001);
    chk("bls_res",  result_o,          16'hFF80);
    step();

    // Same access zero-extended.
    launch(2'b01, 1'b1, 1'b0, 16'h0101, 16'h0000, 16'h0000);
    step();
    chk("blz_done", {15'd0, done_o}, 16'h0001);
    chk("blz_res",  result_o,        16'h0080);
    step();

    // Low-lane byte load of 0x80FF, sign-extended -> 0xFFFF.
    launch(2'b01, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h0000);
    step();
    chk("bll_res", result_o, 16'hFFFF);
    step();

    // Word load with three wait cycles: re for 4 cycles, done at E+5.
    mem_dataIn_i   = 16'hBEEF;
    mem_needWait_i = 1'b1;
    re_cnt         = 0;
    launch(2'b01, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (mem_re_o) re_cnt++;
      chk("wl_nodone", {15'd0, done_o}, 16'h0000);
      chk("wl_addr",   mem_addr_o,      16'h0ABC);
      if (i == 3) mem_needWait_i = 1'b0;
      step();
    end
    chk("wl_re_cycles", re_cnt[15:0],      16'd4);
    chk("wl_done",      {15'd0, done_o},   16'h0001);
    chk("wl_re_off",    {15'd0, mem_re_o}, 16'h0000);
    chk("wl_res",       result_o,          16'hBEEF);
    step();

    // Byte store low lane: read 0x1234, write 0x12AB, done at E+3.
    mem_dataIn_i = 16'h1234;
    launch(2'b10, 1'b1, 1'b0, 16'h0200, 16'h00AB, 16'h0000);
    chk("bs_re",    {15'd0, mem_re_o}, 16'h0001);
    chk("bs_addr",  mem_addr_o,        16'h0200);
    chk("bs_st_rd", {14'd0, state_o},  16'h0001);
    step();
    chk("bs_we",    {15'd0, mem_we_o}, 16'h0001);
    chk("bs_re_off",{15'd0, mem_re_o}, 16'h0000);
    chk("bs_dout",  mem_dataOut_o,     16'h12AB);
    chk("bs_st_wr", {14'd0, state_o},  16'h0002);
    step();
    chk("bs_done",  {15'd0, done_o},   16'h0001);
    chk("bs_res",   result_o,          16'h0000);
    chk("bs_fault", {15'd0, fault_o},  16'h0000);
    step();

    // Byte store high lane: 0x1234 with 0x5A -> 0x5A34.
    launch(2'b10, 1'b1, 1'b0, 16'h0201, 16'hFF5A, 16'h0000);
    chk("bsh_addr", mem_addr_o, 16'h0200);
    step();
    chk("bsh_dout", mem_dataOut_o, 16'h5A34);
    step();
    chk("bsh_done", {15'd0, done_o}, 16'h0001);
    step();

    // Aligned word store: straight to WRITE, done at E+2.
    launch(2'b10, 1'b0, 1'b0, 16'h0010, 16'hC0DE, 16'h0000);
    chk("ws_we",   {15'd0, mem_we_o}, 16'h0001);
    chk("ws_re",   {15'd0, mem_re_o}, 16'h0000);
    chk("ws_dout", mem_dataOut_o,     16'hC0DE);
    chk("ws_addr", mem_addr_o,        16'h0010);
    step();
    chk("ws_done", {15'd0, done_o},   16'h0001);
    step();

    // Misaligned word store: fault at E+1, no strobes.
    launch(2'b10, 1'b0, 1'b0, 16'h0003, 16'hAAAA, 16'h0000);
    chk("mis_st_done",  {15'd0, done_o},   16'h0001);
    chk("mis_st_fault", {15'd0, fault_o},  16'h0001);
    chk("mis_st_res",   result_o,          16'h0000);
    chk("mis_st_re",    {15'd0, mem_re_o}, 16'h0000);
    chk("mis_st_we",    {15'd0, mem_we_o}, 16'h0000);
    step();
    chk("mis_st_hold",  {15'd0, fault_o},  16'h0001);

    // Misaligned word load also faults.
    launch(2'b01, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000);
    chk("mis_ld_done",  {15'd0, done_o},   16'h0001);
    chk("mis_ld_fault", {15'd0, fault_o},  16'h0001);
    chk("mis_ld_re",    {15'd0, mem_re_o}, 16'h0000);
    step();

    // Reserved op behaves as pass and clears fault.
    launch(2'b11, 1'b0, 1'b0, 16'h0007, 16'h0000, 16'h7777);
    chk("rsv_done",  {15'd0, done_o},  16'h0001);
    chk("rsv_res",   result_o,         16'h7777);
    chk("rsv_fault", {15'd0, fault_o}, 16'h0000);
    step();

    // Reset during a waited WRITE: abandoned, everything back to reset values.
    mem_needWait_i = 1'b1;
    launch(2'b10, 1'b0, 1'b0, 16'h0040, 16'hBEAD, 16'h0000);
    chk("rw_we", {15'd0, mem_we_o}, 16'h0001);
    step();
    chk("rw_we_hold",   {15'd0, mem_we_o}, 16'h0001);
    chk("rw_dout_hold", mem_dataOut_o,     16'hBEAD);
    rst = 1'b1;
    step();
    chk_idle_outputs("rw_rst");
    rst            = 1'b0;
    mem_needWait_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_no_done", {15'd0, done_o}, 16'h0000);
    end

    // en while busy is ignored: pass request during a waited load is dropped.
    mem_needWait_i = 1'b1;
    mem_dataIn_i   = 16'h4321;
    launch(2'b01, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0000);
    op_i        = 2'b00;
    aluResult_i = 16'h9999;
    en          = 1'b1;
    step();
    en = 1'b0;
    chk("eb_busy", {15'd0, busy_o},   16'h0001);
    chk("eb_re",   {15'd0, mem_re_o}, 16'h0001);
    mem_needWait_i = 1'b0;
    step();
    chk("eb_done", {15'd0, done_o},   16'h0001);
    chk("eb_res",  result_o,          16'h4321);
    step();
    chk("eb_idle", {15'd0, busy_o},   16'h0000);
    step();
    chk("eb_no_queue_done", {15'd0, done_o}, 16'h0000);
    chk("eb_no_queue_res",  result_o,        16'h4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
